// File: rtl/lzrw_pkg.sv
// lzrw_pkg
//   Shared types, default parameters and helpers for the LZRW1 history window.
//   byte_t   : one stream byte.
//   ptr_t    : 32-bit absolute byte counter (wraps mod 2^32 harmlessly).
//   DEF_*    : default geometry for the history window.
//   ring_idx : absolute counter -> ring position (history must be a power of 2).
package lzrw_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] ptr_t;

    localparam int unsigned DEF_HISTORY   = 4096;
    localparam int unsigned DEF_IN_BYTES  = 16;
    localparam int unsigned DEF_WIN_BYTES = 16;
    localparam int unsigned DEF_LOOKBACK  = 2048;

    function automatic ptr_t ring_idx(input ptr_t cnt, input int unsigned history);
        return cnt & ptr_t'(history - 1);
    endfunction

endpackage

// File: rtl/lzrw_history_ram.sv
// lzrw_history_ram
//   HISTORY x 8 flop ring with one IN_BYTES-wide byte-masked write port and two
//   WIN_BYTES-wide combinational read ports. All ports address consecutive
//   bytes starting at the given ring position and wrap at the end of the ring.
// Ports:
//   clock_i     : rising-edge clock
//   wr_en_i     : write strobe for the whole beat
//   wr_addr_i   : ring position of beat byte 0
//   wr_be_i     : per-byte write enable (bit i -> wr_data_i byte i)
//   wr_data_i   : beat data, byte 0 in bits [7:0]
//   rd_a_addr_i : ring position of read port A byte 0
//   rd_a_data_o : WIN_BYTES bytes starting at rd_a_addr_i
//   rd_b_addr_i : ring position of read port B byte 0
//   rd_b_data_o : WIN_BYTES bytes starting at rd_b_addr_i
// The array is deliberately not reset; the owner masks stale contents.
module lzrw_history_ram
    import lzrw_pkg::*;
#(
    parameter  int unsigned HISTORY   = DEF_HISTORY,
    parameter  int unsigned IN_BYTES  = DEF_IN_BYTES,
    parameter  int unsigned WIN_BYTES = DEF_WIN_BYTES,
    localparam int unsigned AW        = $clog2(HISTORY)
) (
    input  logic                   clock_i,
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [IN_BYTES-1:0]    wr_be_i,
    input  logic [IN_BYTES*8-1:0]  wr_data_i,
    input  logic [AW-1:0]          rd_a_addr_i,
    output logic [WIN_BYTES*8-1:0] rd_a_data_o,
    input  logic [AW-1:0]          rd_b_addr_i,
    output logic [WIN_BYTES*8-1:0] rd_b_data_o
);

    byte_t mem_q [HISTORY];

    // AW-bit address arithmetic gives the ring wrap for free.
    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            for (int i = 0; i < IN_BYTES; i++) begin
                if (wr_be_i[i]) begin
                    mem_q[wr_addr_i + AW'(i)] <= wr_data_i[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_a_data_o = '0;
        rd_b_data_o = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            rd_a_data_o[8*i +: 8] = mem_q[rd_a_addr_i + AW'(i)];
            rd_b_data_o[8*i +: 8] = mem_q[rd_b_addr_i + AW'(i)];
        end
    end

endmodule

// File: rtl/lzrw_history_window.sv
// lzrw_history_window
//   History ring and match-window source for the LZRW1 compressor. Input beats
//   are written behind a 32-bit absolute write counter; the encoder retires
//   bytes by advancing a 32-bit read counter (the cursor). Every cycle the block
//   presents the look-ahead window at the cursor, the 3-byte hash key and a
//   compare window at cursor - match_offset.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
//   in_ready is a function of registered state only (never of in_valid); once
//   a beat carrying in_last transfers, in_ready stays low until reset.
//   Advances have no back-pressure: adv_valid takes effect only while
//   out_valid is high and is silently ignored otherwise.
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   in_valid/in_ready       : input beat handshake
//   in_data/in_count/in_last: beat bytes (byte 0 oldest), valid count, end of stream
//   adv_valid/adv_len       : retire adv_len bytes (0 means 1, clamped to avail)
//   match_offset            : distance back from the cursor for the compare window
//   out_valid               : window outputs meaningful
//   cur_window/cur_mask     : bytes at cursor+i and their validity
//   cmp_window/cmp_mask     : bytes at cursor-offset+i and their validity
//   hash_key/hash_valid     : {cur[0],cur[1],cur[2]} when 3 bytes are available
//   byte_ptr                : cursor as an absolute byte count
//   done                    : stream fully consumed (sticky until reset)
module lzrw_history_window
    import lzrw_pkg::*;
#(
    parameter  int unsigned HISTORY   = DEF_HISTORY,
    parameter  int unsigned IN_BYTES  = DEF_IN_BYTES,
    parameter  int unsigned WIN_BYTES = DEF_WIN_BYTES,
    parameter  int unsigned LOOKBACK  = DEF_LOOKBACK,
    localparam int unsigned AW        = $clog2(HISTORY),
    localparam int unsigned IN_CW     = $clog2(IN_BYTES) + 1,
    localparam int unsigned ADV_W     = $clog2(WIN_BYTES) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_BYTES*8-1:0]  in_data,
    input  logic [IN_CW-1:0]       in_count,
    input  logic                   in_last,
    input  logic                   adv_valid,
    input  logic [ADV_W-1:0]       adv_len,
    input  logic [AW-1:0]          match_offset,
    output logic                   out_valid,
    output logic [WIN_BYTES*8-1:0] cur_window,
    output logic [WIN_BYTES-1:0]   cur_mask,
    output logic [WIN_BYTES*8-1:0] cmp_window,
    output logic [WIN_BYTES-1:0]   cmp_mask,
    output logic [23:0]            hash_key,
    output logic                   hash_valid,
    output logic [31:0]            byte_ptr,
    output logic                   done
);

    ptr_t wr_cnt_q, wr_cnt_d;
    ptr_t rd_cnt_q, rd_cnt_d;
    logic last_seen_q, last_seen_d;
    logic done_q, done_d;

    ptr_t avail;
    logic accept;
    logic adv_fire;
    ptr_t adv_req;
    ptr_t adv_amt;
    logic [IN_BYTES-1:0] wr_be;

    ptr_t off_ext;
    ptr_t cmp_limit;
    logic off_ok;

    logic [AW-1:0]          wr_addr;
    logic [AW-1:0]          cur_addr;
    logic [AW-1:0]          cmp_addr;
    logic [WIN_BYTES*8-1:0] cur_raw;
    logic [WIN_BYTES*8-1:0] cmp_raw;

    // Occupancy is a mod-2^32 difference, so counter wrap never matters.
    assign avail = wr_cnt_q - rd_cnt_q;

    // Keep LOOKBACK bytes behind the cursor intact: a beat may only land if
    // the unread bytes plus a full beat still leave the lookback region alone.
    assign in_ready  = !last_seen_q &&
                       ((avail + ptr_t'(IN_BYTES)) <= ptr_t'(HISTORY - LOOKBACK));
    assign out_valid = (avail >= ptr_t'(WIN_BYTES)) || (last_seen_q && (avail != '0));
    assign accept    = in_valid && in_ready;
    assign adv_fire  = adv_valid && out_valid;

    always_comb begin
        wr_be = '0;
        for (int i = 0; i < IN_BYTES; i++) begin
            wr_be[i] = (IN_CW'(i) < in_count);
        end
    end

    always_comb begin
        adv_req     = (adv_len == '0) ? ptr_t'(1) : ptr_t'(adv_len);
        adv_amt     = (adv_req > avail) ? avail : adv_req;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        last_seen_d = last_seen_q;
        if (accept) begin
            wr_cnt_d = wr_cnt_q + ptr_t'(in_count);
            if (in_last) begin
                last_seen_d = 1'b1;
            end
        end
        if (adv_fire) begin
            rd_cnt_d = rd_cnt_q + adv_amt;
        end
        // Evaluated on next-state values so done rises the cycle right after
        // the advance that empties a finished stream.
        done_d = done_q || (last_seen_d && (rd_cnt_d == wr_cnt_d));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            last_seen_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            last_seen_q <= last_seen_d;
            done_q      <= done_d;
        end
    end

    // Offsets reaching before byte 0 of the stream (or beyond the retained
    // lookback) would read stale ring contents, so they are rejected.
    assign off_ext   = ptr_t'(match_offset);
    assign off_ok    = (off_ext != '0) && (off_ext <= ptr_t'(LOOKBACK)) && (off_ext <= rd_cnt_q);
    // Compare bytes may run past the cursor into the look-ahead (run-length
    // matches); they stay valid as long as they have already been written.
    assign cmp_limit = off_ext + avail;

    assign wr_addr  = AW'(ring_idx(wr_cnt_q, HISTORY));
    assign cur_addr = AW'(ring_idx(rd_cnt_q, HISTORY));
    assign cmp_addr = AW'(ring_idx(rd_cnt_q - off_ext, HISTORY));

    lzrw_history_ram #(
        .HISTORY   (HISTORY),
        .IN_BYTES  (IN_BYTES),
        .WIN_BYTES (WIN_BYTES)
    ) u_ram (
        .clock_i     (clock),
        .wr_en_i     (accept),
        .wr_addr_i   (wr_addr),
        .wr_be_i     (wr_be),
        .wr_data_i   (in_data),
        .rd_a_addr_i (cur_addr),
        .rd_a_data_o (cur_raw),
        .rd_b_addr_i (cmp_addr),
        .rd_b_data_o (cmp_raw)
    );

    always_comb begin
        cur_mask   = '0;
        cur_window = '0;
        cmp_mask   = '0;
        cmp_window = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            if (ptr_t'(i) < avail) begin
                cur_mask[i]          = 1'b1;
                cur_window[8*i +: 8] = cur_raw[8*i +: 8];
            end
            if (off_ok && (ptr_t'(i) < cmp_limit)) begin
                cmp_mask[i]          = 1'b1;
                cmp_window[8*i +: 8] = cmp_raw[8*i +: 8];
            end
        end
    end

    // Masked window bytes are already zero, so the key needs no extra gating
    // beyond the availability check.
    assign hash_valid = (avail >= ptr_t'(3));
    assign hash_key   = hash_valid ? {cur_window[7:0], cur_window[15:8], cur_window[23:16]} : 24'h0;

    assign byte_ptr = rd_cnt_q;
    assign done     = done_q;

endmodule

// File: tb/tb_lzrw_history_window.sv
// tb_lzrw_history_window
//   Self-checking bench for lzrw_history_window. A reference model holds the
//   stream in a flat array indexed by absolute byte position plus write/read
//   counts; every cycle one compare process derives all outputs from it, and a
//   byte queue of accepted data is popped on every advance to catch lost or
//   duplicated bytes. Directed sequences add literal expectations.
module tb_lzrw_history_window;

    localparam int unsigned H  = 4096;
    localparam int unsigned IB = 16;
    localparam int unsigned WB = 16;
    localparam int unsigned LB = 2048;

    logic                   clock;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [IB*8-1:0]        in_data;
    logic [$clog2(IB):0]    in_count;
    logic                   in_last;
    logic                   adv_valid;
    logic [$clog2(WB):0]    adv_len;
    logic [$clog2(H)-1:0]   match_offset;
    logic                   out_valid;
    logic [WB*8-1:0]        cur_window;
    logic [WB-1:0]          cur_mask;
    logic [WB*8-1:0]        cmp_window;
    logic [WB-1:0]          cmp_mask;
    logic [23:0]            hash_key;
    logic                   hash_valid;
    logic [31:0]            byte_ptr;
    logic                   done;

    lzrw_history_window #(
        .HISTORY   (H),
        .IN_BYTES  (IB),
        .WIN_BYTES (WB),
        .LOOKBACK  (LB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_count     (in_count),
        .in_last      (in_last),
        .adv_valid    (adv_valid),
        .adv_len      (adv_len),
        .match_offset (match_offset),
        .out_valid    (out_valid),
        .cur_window   (cur_window),
        .cur_mask     (cur_mask),
        .cmp_window   (cmp_window),
        .cmp_mask     (cmp_mask),
        .hash_key     (hash_key),
        .hash_valid   (hash_valid),
        .byte_ptr     (byte_ptr),
        .done         (done)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_data [0:65535];
    logic [31:0] m_wr   = 0;
    logic [31:0] m_rd   = 0;
    bit          m_last = 0;
    bit          m_done = 0;
    logic [7:0]  exp_q [$];

    function automatic logic [7:0] m_byte(input logic [31:0] pos);
        return m_data[16'(pos)];
    endfunction

    task automatic model_check();
        logic [31:0]     avail, off;
        logic [WB*8-1:0] e_cw, e_pw;
        logic [WB-1:0]   e_cm, e_pm;
        logic            e_ok, e_hv, e_rdy, e_ov;
        logic [23:0]     e_hk;
        avail = m_wr - m_rd;
        e_rdy = !m_last && (avail + IB <= H - LB);
        e_ov  = (avail >= WB) || (m_last && avail > 0);
        e_cw = '0; e_cm = '0; e_pw = '0; e_pm = '0;
        for (int i = 0; i < WB; i++) begin
            if (32'(i) < avail) begin
                e_cm[i]          = 1'b1;
                e_cw[8*i +: 8]   = m_byte(m_rd + 32'(i));
            end
        end
        off  = 32'(match_offset);
        e_ok = (off != 0) && (off <= LB) && (off <= m_rd);
        for (int i = 0; i < WB; i++) begin
            if (e_ok && (32'(i) < off + avail)) begin
                e_pm[i]        = 1'b1;
                e_pw[8*i +: 8] = m_byte(m_rd - off + 32'(i));
            end
        end
        e_hv = (avail >= 3);
        e_hk = e_hv ? {m_byte(m_rd), m_byte(m_rd + 1), m_byte(m_rd + 2)} : 24'h0;
        chk("in_ready",   128'(in_ready),   128'(e_rdy));
        chk("out_valid",  128'(out_valid),  128'(e_ov));
        chk("cur_mask",   128'(cur_mask),   128'(e_cm));
        chk("cur_window", 128'(cur_window), 128'(e_cw));
        chk("cmp_mask",   128'(cmp_mask),   128'(e_pm));
        chk("cmp_window", 128'(cmp_window), 128'(e_pw));
        chk("hash_valid", 128'(hash_valid), 128'(e_hv));
        chk("hash_key",   128'(hash_key),   128'(e_hk));
        chk("byte_ptr",   128'(byte_ptr),   128'(m_rd));
        chk("done",       128'(done),       128'(m_done));
    endtask

    // Applies the inputs that the coming rising edge will sample.
    task automatic model_update();
        logic [31:0] avail, amt;
        logic [7:0]  b;
        bit          acc, ov;
        if (reset) begin
            m_wr = 0; m_rd = 0; m_last = 0; m_done = 0;
            exp_q.delete();
        end else begin
            avail = m_wr - m_rd;
            acc   = in_valid && !m_last && (avail + IB <= H - LB);
            ov    = (avail >= WB) || (m_last && avail > 0);
            if (adv_valid && ov) begin
                amt = (adv_len == 0) ? 32'd1 : 32'(adv_len);
                if (amt > avail) amt = avail;
                for (int j = 0; j < int'(amt); j++) begin
                    b = exp_q.pop_front();
                    if (chk_en) chk("sb_byte", 128'(cur_window[8*j +: 8]), 128'(b));
                end
                m_rd = m_rd + amt;
            end
            if (acc) begin
                for (int j = 0; j < int'(in_count); j++) begin
                    m_data[16'(m_wr + 32'(j))] = in_data[8*j +: 8];
                    exp_q.push_back(in_data[8*j +: 8]);
                end
                m_wr = m_wr + 32'(in_count);
                if (in_last) m_last = 1;
            end
            if (m_last && (m_wr == m_rd)) m_done = 1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) model_check();
            model_update();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        adv_valid = 1'b0;
        in_last   = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [IB*8-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rand_offset();
        match_offset = 12'($urandom_range(0, LB + 64));
    endtask

    // ---------------- stimulus ----------------
    int          beats;
    int          guard;
    int          k;
    logic [31:0] total;
    bit          acc;
    bit          sent_last;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_count = 5'd16; in_last = 1'b0;
        adv_valid = 1'b0; adv_len = 5'd1; match_offset = '0;
        do_reset();
        chk_en = 1'b1;
        #1;
        chk("rst_in_ready",  128'(in_ready),  128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_byte_ptr",  128'(byte_ptr),  128'(0));

        // Single full beat "A".."P" closing the stream, then one 16-byte advance.
        in_data  = 128'h504F4E4D4C4B4A494847464544434241;
        in_count = 5'd16; in_last = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("t1_out_valid", 128'(out_valid), 128'(1));
        chk("t1_hash_key",  128'(hash_key),  128'(24'h414243));
        chk("t1_cur_mask",  128'(cur_mask),  128'(16'hFFFF));
        adv_valid = 1'b1; adv_len = 5'd16;
        step();
        adv_valid = 1'b0;
        #1;
        chk("t1_done",     128'(done),     128'(1));
        chk("t1_byte_ptr", 128'(byte_ptr), 128'(16));
        step();
        chk("t1_done_hold", 128'(done), 128'(1));

        // Short last beat: mask, zeroed tail, adv_len 0 -> 1, oversize clamp.
        do_reset();
        in_data = rand_beat(); in_count = 5'd5; in_last = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("t2_cur_mask", 128'(cur_mask), 128'(16'h001F));
        chk("t2_win_tail", 128'(cur_window[127:40]), 128'(0));
        adv_valid = 1'b1; adv_len = 5'd0;
        step();
        chk("t2_ptr_len0", 128'(byte_ptr), 128'(1));
        adv_len = 5'd9;
        step();
        adv_valid = 1'b0;
        chk("t2_ptr_clamp", 128'(byte_ptr), 128'(5));
        chk("t2_done",      128'(done),     128'(1));

        // Overlapping match over "ABCABCABC".
        do_reset();
        in_data  = {56'h0, 72'h434241434241434241};
        in_count = 5'd9; in_last = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        adv_valid = 1'b1; adv_len = 5'd3;
        step();
        adv_valid = 1'b0; match_offset = 12'd3;
        #1;
        chk("t3_ptr",      128'(byte_ptr),          128'(3));
        chk("t3_cmp_lo",   128'(cmp_window[47:0]),  128'(48'h434241434241));
        // offset 3 + 6 unread bytes -> nine valid compare bytes
        chk("t3_cmp_mask", 128'(cmp_mask),          128'(16'h01FF));
        adv_valid = 1'b1; adv_len = 5'd3;
        step();
        adv_valid = 1'b0;
        #1;
        chk("t3_cmp_mask6", 128'(cmp_mask),   128'(16'h003F));
        chk("t3_cmp_win6",  128'(cmp_window), 128'(48'h434241434241));
        match_offset = 12'd0;
        #1;
        chk("t3_off0_mask", 128'(cmp_mask),   128'(0));
        chk("t3_off0_win",  128'(cmp_window), 128'(0));
        match_offset = 12'd7;
        #1;
        chk("t3_offbig_mask", 128'(cmp_mask), 128'(0));

        // Fill with no advances until back-pressure, then stream 3*H bytes
        // while advancing 16 per cycle.
        do_reset();
        in_valid = 1'b1; in_count = 5'd16; in_last = 1'b0;
        beats = 0; guard = 0;
        while (in_ready && guard < 400) begin
            in_data = rand_beat(); rand_offset();
            step();
            beats++; guard++;
        end
        chk("t4_fill_beats", 128'(beats), 128'((H - LB) / IB));
        in_data = rand_beat();
        step();
        chk("t4_stall_ready", 128'(in_ready), 128'(0));
        total = 32'(beats * IB);
        sent_last = 1'b0; guard = 0;
        adv_valid = 1'b1; adv_len = 5'd16;
        while (!sent_last && guard < 6000) begin
            k         = $urandom_range(1, IB);
            in_count  = 5'(k);
            in_data   = rand_beat();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = (total + 32'(k) >= 3 * H);
            rand_offset();
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                total = total + 32'(k);
                if (in_last) sent_last = 1'b1;
            end
            guard++;
        end
        chk("t4_last_sent", 128'(sent_last), 128'(1));
        in_valid = 1'b0; in_last = 1'b0;
        guard = 0;
        while (!done && guard < 1000) begin
            rand_offset();
            step();
            guard++;
        end
        adv_valid = 1'b0;
        chk("t4_done", 128'(done),     128'(1));
        chk("t4_ptr",  128'(byte_ptr), 128'(total));

        // Matched accept and advance every cycle keeps occupancy fixed.
        do_reset();
        in_valid = 1'b1; in_count = 5'd16; in_last = 1'b0;
        in_data = rand_beat(); step();
        in_data = rand_beat(); step();
        total = 0;
        for (int c = 0; c < 1000; c++) begin
            k         = $urandom_range(1, IB);
            in_count  = 5'(k);
            adv_len   = 5'(k);
            in_data   = rand_beat();
            adv_valid = 1'b1;
            rand_offset();
            total = total + 32'(k);
            step();
        end
        in_valid = 1'b0; adv_valid = 1'b0;
        #1;
        chk("t5_ptr",       128'(byte_ptr), 128'(total));
        chk("t5_out_valid", 128'(out_valid), 128'(1));

        // Reset mid-stream with accept and advance both requested.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            in_valid  = 1'b1; in_count = 5'($urandom_range(1, IB)); in_data = rand_beat();
            adv_valid = ($urandom_range(0, 1) == 1); adv_len = 5'($urandom_range(0, WB));
            rand_offset();
            step();
        end
        reset = 1'b1; in_valid = 1'b1; adv_valid = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0; adv_valid = 1'b0; match_offset = 12'd5;
        #1;
        chk("t6_in_ready",   128'(in_ready),   128'(1));
        chk("t6_out_valid",  128'(out_valid),  128'(0));
        chk("t6_byte_ptr",   128'(byte_ptr),   128'(0));
        chk("t6_cur_mask",   128'(cur_mask),   128'(0));
        chk("t6_cur_window", 128'(cur_window), 128'(0));
        chk("t6_cmp_mask",   128'(cmp_mask),   128'(0));
        chk("t6_hash_key",   128'(hash_key),   128'(0));
        chk("t6_done",       128'(done),       128'(0));
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "watchdog");
    end

endmodule
